reset_sequencer: RTL and testbench
==================================

// Module: reset_sequencer
// PURPOSE
//  Parametrised successor of the board reset controller. It drives NUM_CH peripheral reset domains
//  (ADC writer, DAC synth, PDM, ...) from the software config word, a trigger, a watchdog and an
//  instant-reset pin. It adds staggered per-channel release, a latched watchdog fault and synchronised inputs.
//  It sits between the PS config/status registers and every peripheral aresetn in the PL.
// PARAMETERS
//  NUM_CH             4         number of reset domains (1..16)
//  RELEASE_DELAY      125000    cycles between successive channel releases (0 = all at once)
//  WD_TIMEOUT         12500000  cycles without a watchdog edge before fault (100 ms @125 MHz)
//  ALIVE_LOW          12500000  alive_signal low cycles per period
//  ALIVE_HIGH         1250000   alive_signal high cycles per period
//  SYNC_STAGES        2         flip-flops in each pin synchroniser (>=2)
//  DEBOUNCE_CYCLES    1024      trigger stable time, used only with TRIG_DEBOUNCE_EN
// PORTS
//  clk                in   1       system clock, 125 MHz
//  peripheral_areset  in   1       asynchronous, active-high reset
//  reset_cfg          in   8       config word; see BEHAVIOUR
//  ch_mask            in   NUM_CH  1 = channel gated by trigger/watchdog/instant; 0 = free-running
//  trigger_in         in   1       external trigger pin (async)
//  watchdog_in        in   1       watchdog toggle pin (async)
//  instant_reset_in   in   1       instant-reset pin (async)
//  ch_aresetn         out  NUM_CH  per-domain active-low resets
//  fault_latched      out  1       watchdog fault is latched
//  reset_ack          out  1       high while in FAULT or in instant-reset hold
//  alive_signal       out  1       heartbeat
//  master_trigger     out  1       registered copy of reset_cfg[2]
//  reset_sts          out  32      status word
// BEHAVIOUR
//  Reset: every output is 0, the FSM is in HOLD, and all counters are 0.
//  cfg bits: [0] trigger mode, [1] watchdog enable, [2] master trigger, [3] instant reset enable,
//   [4] 1 = external trigger, [5] internal trigger, [6] fault clear (level), [7] reserved (ignored).
//  Pins: each pin passes through SYNC_STAGES flops (trig_s, wd_s, inst_s).
//   Latency from pin to ch_aresetn is SYNC_STAGES+1 cycles.
//  Request logic:
//   trig = cfg[4] ? trig_s : cfg[5].
//   run_req = cfg[0] ? trig : 1.
//   inst = inst_s & cfg[3].
//  Watchdog: counter wd_cnt clears on any wd_s edge and otherwise increments, saturating at WD_TIMEOUT.
//   wd_to = cfg[1] & (wd_cnt == WD_TIMEOUT).
//  FSM priority: peripheral_areset > wd_to > inst > run_req.
//   HOLD  -> FAULT if wd_to; -> SEQ if run_req & !inst.
//   SEQ   -> FAULT if wd_to; -> HOLD if inst | !run_req; -> RUN when the last channel is released.
//   RUN   -> FAULT if wd_to; -> HOLD if inst | !run_req.
//   FAULT -> HOLD only when cfg[6]==1 and !wd_to. Clearing cfg[1] alone does not exit FAULT.
//  SEQ: seq_cnt starts at 0 on entry.
//   Gated channel i releases (ch_aresetn[i]=1) once seq_cnt >= i*RELEASE_DELAY and stays released.
//   seq_cnt saturates at (NUM_CH-1)*RELEASE_DELAY.
//   If RELEASE_DELAY==0, SEQ lasts 1 cycle.
//  Gated channels are 0 in HOLD and FAULT. Every gated channel drops in the same cycle the FSM leaves SEQ/RUN.
//  Ungated channels (ch_mask[i]==0) go to 1 on the first clk after reset deassertion and ignore the FSM.
//   Changing ch_mask mid-run takes effect on the next cycle.
//  fault_latched = (state == FAULT).
//   reset_ack = FAULT | (inst & state == HOLD).
//   Both are registered.
//  Alive counter: period ALIVE_LOW+ALIVE_HIGH, low phase first, wraps to 0.
//  reset_sts layout:
//   [NUM_CH-1:0] ch_aresetn; [17:16] state (HOLD=0, SEQ=1, RUN=2, FAULT=3); [18] trig_s; [19] wd_s;
//   [20] inst_s; [21] fault_latched; [22] master_trigger; all other bits 0.
// CONFIGURATION
//  TRIG_DEBOUNCE_EN defined:
//   trig_s is replaced by a debounced copy that changes only after the synchronised pin has been stable
//   for DEBOUNCE_CYCLES consecutive cycles. This adds DEBOUNCE_CYCLES of latency.
//  TRIG_DEBOUNCE_EN undefined: trig_s is the plain synchroniser output and DEBOUNCE_CYCLES is unused.
// STRUCTURE
//  reset_seq_pkg holds:
//   the state enum (HOLD/SEQ/RUN/FAULT);
//   the cfg bit index constants (CFG_TRIG_MODE ... CFG_FAULT_CLR);
//   the reset_sts field offsets.
//  Sub-module reset_sync_in: SYNC_STAGES synchroniser, optional debouncer and edge pulse output.
//   It is instantiated once per pin.
//  Counter widths use $clog2 of the largest value each counter reaches.
// TESTING
//  1. Reset, cfg=0x00, NUM_CH=4, RELEASE_DELAY=10, ch_mask=4'hF
//     -> ch_aresetn releases bit 0 at t, bit 1 at t+10, bit 2 at t+20, bit 3 at t+30; state RUN after bit 3.
//  2. cfg=0x11, trigger pulse high for 100 cycles
//     -> sequence starts SYNC_STAGES+1 cycles after the rising edge; all gated channels drop
//        SYNC_STAGES+1 cycles after the falling edge.
//  3. cfg=0x02, toggle watchdog every 1 M cycles, then stop
//     -> FAULT exactly WD_TIMEOUT cycles after the last edge; fault_latched=1, ch_aresetn=0.
//     -> Resume toggling: FAULT holds. Set cfg[6]=1: HOLD, then SEQ.
//  4. RUN with cfg=0x08, instant_reset_in high for 5 cycles
//     -> gated channels go 0 and reset_ack=1 while held; the sequence restarts from channel 0 after release.
//  5. ch_mask=4'b0101 in FAULT -> ch_aresetn[1] and [3] stay 1; [0] and [2] stay 0.
//  6. Assert peripheral_areset mid-SEQ -> all outputs 0 immediately (async); state HOLD.

Source files
------------

// File: rtl/reset_seq_pkg.sv
// reset_seq_pkg: shared FSM states, config bit indices and status word offsets for reset_sequencer
package reset_seq_pkg;
  typedef enum logic [1:0] {HOLD = 2'd0, SEQ = 2'd1, RUN = 2'd2, FAULT = 2'd3} state_t;
  localparam int CFG_TRIG_MODE = 0;
  localparam int CFG_WD_EN = 1;
  localparam int CFG_MASTER = 2;
  localparam int CFG_INST_EN = 3;
  localparam int CFG_EXT_TRIG = 4;
  localparam int CFG_INT_TRIG = 5;
  localparam int CFG_FAULT_CLR = 6;
  localparam int STS_STATE = 16;
  localparam int STS_TRIG = 18;
  localparam int STS_WD = 19;
  localparam int STS_INST = 20;
  localparam int STS_FAULT = 21;
  localparam int STS_MASTER = 22;
  function automatic int cw(input longint v);
    return (v < 2) ? 1 : $clog2(v + 1);
  endfunction
endpackage

// File: rtl/reset_sync_in.sv
// reset_sync_in: STAGES-deep pin synchroniser with optional debouncer (DB_CYCLES>0) and change pulse
module reset_sync_in #(
  parameter int STAGES = 2,
  parameter int DB_CYCLES = 0
) (
  input  logic clk,
  input  logic rst,
  input  logic pin,
  output logic sync,
  output logic edge_p
);
  logic [STAGES-1:0] ff;
  logic nxt;
  always_ff @(posedge clk or posedge rst)
    if (rst) ff <= '0;
    else ff <= {ff[STAGES-2:0], pin};
  generate
    if (DB_CYCLES > 0) begin : g_db
      localparam int CW = $clog2(DB_CYCLES + 1);
      logic [CW-1:0] cnt;
      assign nxt = ((ff[STAGES-1] != sync) && (cnt == CW'(DB_CYCLES - 1))) ? ff[STAGES-1] : sync;
      always_ff @(posedge clk or posedge rst)
        if (rst) begin
          cnt <= '0;
          sync <= 1'b0;
        end else begin
          cnt <= (ff[STAGES-1] == sync) ? '0 : cnt + 1'b1;
          sync <= nxt;
        end
    end else begin : g_raw
      assign nxt = ff[STAGES-2];
      assign sync = ff[STAGES-1];
    end
  endgenerate
  // Pulse in the cycle before sync changes so counters clear on the same edge
  assign edge_p = nxt ^ sync;
endmodule

// File: rtl/reset_sequencer.sv
// reset_sequencer: staggered per-domain reset release with watchdog fault latch and instant reset.
// Define TRIG_DEBOUNCE_EN to debounce the trigger pin for DEBOUNCE_CYCLES.
module reset_sequencer
  import reset_seq_pkg::*;
#(
  parameter int NUM_CH = 4,
  parameter int RELEASE_DELAY = 125000,
  parameter int WD_TIMEOUT = 12500000,
  parameter int ALIVE_LOW = 12500000,
  parameter int ALIVE_HIGH = 1250000,
  parameter int SYNC_STAGES = 2,
  parameter int DEBOUNCE_CYCLES = 1024
) (
  input  logic              clk,
  input  logic              peripheral_areset,
  input  logic [7:0]        reset_cfg,
  input  logic [NUM_CH-1:0] ch_mask,
  input  logic              trigger_in,
  input  logic              watchdog_in,
  input  logic              instant_reset_in,
  output logic [NUM_CH-1:0] ch_aresetn,
  output logic              fault_latched,
  output logic              reset_ack,
  output logic              alive_signal,
  output logic              master_trigger,
  output logic [31:0]       reset_sts
);
  localparam int SEQ_MAX = (NUM_CH - 1) * RELEASE_DELAY;
  localparam int SEQ_W = cw(SEQ_MAX);
  localparam int WD_W = cw(WD_TIMEOUT);
  localparam int AW = cw(ALIVE_LOW + ALIVE_HIGH - 1);
`ifdef TRIG_DEBOUNCE_EN
  localparam int TRIG_DB = DEBOUNCE_CYCLES;
`else
  localparam int TRIG_DB = 0;
`endif
  state_t st, nxt;
  logic trig_s, wd_s, inst_s, trig_e, wd_e, inst_e;
  logic trig, run_req, inst, wd_to, unused;
  logic [SEQ_W-1:0] seq_cnt, seq_nxt;
  logic [WD_W-1:0] wd_cnt;
  logic [AW-1:0] alive_cnt, alive_nxt;
  logic [NUM_CH-1:0] rel;
  reset_sync_in #(.STAGES(SYNC_STAGES), .DB_CYCLES(TRIG_DB)) u_trig (
    .clk(clk), .rst(peripheral_areset), .pin(trigger_in), .sync(trig_s), .edge_p(trig_e));
  reset_sync_in #(.STAGES(SYNC_STAGES), .DB_CYCLES(0)) u_wd (
    .clk(clk), .rst(peripheral_areset), .pin(watchdog_in), .sync(wd_s), .edge_p(wd_e));
  reset_sync_in #(.STAGES(SYNC_STAGES), .DB_CYCLES(0)) u_inst (
    .clk(clk), .rst(peripheral_areset), .pin(instant_reset_in), .sync(inst_s), .edge_p(inst_e));
  assign unused = ^{reset_cfg[7], trig_e, inst_e, DEBOUNCE_CYCLES[0]};
  // Outputs are registered from the next state so they move on the same edge as the FSM
  always_comb begin
    trig = reset_cfg[CFG_EXT_TRIG] ? trig_s : reset_cfg[CFG_INT_TRIG];
    run_req = reset_cfg[CFG_TRIG_MODE] ? trig : 1'b1;
    inst = inst_s & reset_cfg[CFG_INST_EN];
    wd_to = reset_cfg[CFG_WD_EN] & (wd_cnt == WD_W'(WD_TIMEOUT));
    nxt = wd_to ? FAULT :
          (st == FAULT) ? (reset_cfg[CFG_FAULT_CLR] ? HOLD : FAULT) :
          (inst | !run_req) ? HOLD :
          (st == HOLD) ? SEQ :
          (st == SEQ) ? ((seq_cnt == SEQ_W'(SEQ_MAX)) ? RUN : SEQ) : RUN;
    seq_nxt = (st == SEQ && nxt == SEQ) ?
              ((seq_cnt == SEQ_W'(SEQ_MAX)) ? seq_cnt : seq_cnt + 1'b1) : '0;
    alive_nxt = (alive_cnt == AW'(ALIVE_LOW + ALIVE_HIGH - 1)) ? '0 : alive_cnt + 1'b1;
    for (int i = 0; i < NUM_CH; i++)
      rel[i] = (nxt == RUN) | ((nxt == SEQ) & (int'(seq_nxt) >= i * RELEASE_DELAY));
  end
  always_ff @(posedge clk or posedge peripheral_areset)
    if (peripheral_areset) begin
      st <= HOLD;
      seq_cnt <= '0;
      wd_cnt <= '0;
      alive_cnt <= '0;
      ch_aresetn <= '0;
      fault_latched <= 1'b0;
      reset_ack <= 1'b0;
      alive_signal <= 1'b0;
      master_trigger <= 1'b0;
    end else begin
      st <= nxt;
      seq_cnt <= seq_nxt;
      wd_cnt <= wd_e ? '0 : (wd_cnt == WD_W'(WD_TIMEOUT)) ? wd_cnt : wd_cnt + 1'b1;
      alive_cnt <= alive_nxt;
      ch_aresetn <= ~ch_mask | rel;
      fault_latched <= nxt == FAULT;
      reset_ack <= (nxt == FAULT) | (inst & (nxt == HOLD));
      alive_signal <= alive_nxt >= AW'(ALIVE_LOW);
      master_trigger <= reset_cfg[CFG_MASTER];
    end
  always_comb begin
    reset_sts = '0;
    reset_sts[NUM_CH-1:0] = ch_aresetn;
    reset_sts[STS_STATE +: 2] = st;
    reset_sts[STS_TRIG] = trig_s;
    reset_sts[STS_WD] = wd_s;
    reset_sts[STS_INST] = inst_s;
    reset_sts[STS_FAULT] = fault_latched;
    reset_sts[STS_MASTER] = master_trigger;
  end
endmodule

// File: tb/tb_reset_sequencer.sv
// tb_reset_sequencer: directed checks of release staggering, trigger, watchdog fault, instant reset and async reset
module tb_reset_sequencer;
  logic clk = 1'b0;
  logic peripheral_areset;
  logic [7:0] reset_cfg;
  logic [3:0] ch_mask, ch_aresetn;
  logic trigger_in, watchdog_in, instant_reset_in;
  logic fault_latched, reset_ack, alive_signal, master_trigger;
  logic [31:0] reset_sts;
  int n_tests = 0;
  int n_fail = 0;
  int highs;
  reset_sequencer #(
    .NUM_CH(4), .RELEASE_DELAY(10), .WD_TIMEOUT(200), .ALIVE_LOW(5),
    .ALIVE_HIGH(3), .SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk(clk), .peripheral_areset(peripheral_areset), .reset_cfg(reset_cfg), .ch_mask(ch_mask),
    .trigger_in(trigger_in), .watchdog_in(watchdog_in), .instant_reset_in(instant_reset_in),
    .ch_aresetn(ch_aresetn), .fault_latched(fault_latched), .reset_ack(reset_ack),
    .alive_signal(alive_signal), .master_trigger(master_trigger), .reset_sts(reset_sts)
  );
  always #5 clk = ~clk;
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask
  task automatic step(input int n);
    repeat (n) @(negedge clk);
  endtask
  function automatic logic [31:0] st();
    return 32'(reset_sts[17:16]);
  endfunction
  function automatic logic [31:0] ch();
    return 32'(ch_aresetn);
  endfunction
  initial begin
    peripheral_areset = 1'b1;
    reset_cfg = 8'h00;
    ch_mask = 4'hF;
    trigger_in = 1'b0;
    watchdog_in = 1'b0;
    instant_reset_in = 1'b0;
    step(3);
    check("rst_ch", ch(), 0);
    check("rst_sts", reset_sts, 0);
    check("rst_flags", 32'({fault_latched, reset_ack, alive_signal, master_trigger}), 0);
    peripheral_areset = 1'b0;
    step(1);
    check("t1_ch0", ch(), 4'h1);
    check("t1_seq", st(), 1);
    step(9);
    check("t1_ch0_hold", ch(), 4'h1);
    step(1);
    check("t1_ch1", ch(), 4'h3);
    step(10);
    check("t1_ch2", ch(), 4'h7);
    step(9);
    check("t1_ch2_hold", ch(), 4'h7);
    step(1);
    check("t1_ch3", ch(), 4'hF);
    check("t1_still_seq", st(), 1);
    step(1);
    check("t1_run", st(), 2);
    highs = 0;
    for (int i = 0; i < 16; i++) begin
      step(1);
      highs += int'(alive_signal);
    end
    check("alive_duty", 32'(highs), 6);
    reset_cfg = 8'h04;
    step(1);
    check("master", 32'(master_trigger), 1);
    check("sts_master", 32'(reset_sts[22]), 1);
    check("master_run", st(), 2);
    reset_cfg = 8'h11;
    step(1);
    check("t2_hold_ch", ch(), 0);
    check("t2_hold", st(), 0);
    trigger_in = 1'b1;
    step(2);
    check("t2_rise_early", ch(), 0);
    step(1);
    check("t2_rise_ch", ch(), 4'h1);
    check("t2_rise_seq", st(), 1);
    step(97);
    check("t2_run_ch", ch(), 4'hF);
    check("t2_run", st(), 2);
    check("t2_sts_trig", 32'(reset_sts[18]), 1);
    trigger_in = 1'b0;
    step(2);
    check("t2_fall_early", ch(), 4'hF);
    step(1);
    check("t2_fall_ch", ch(), 0);
    check("t2_fall_hold", st(), 0);
    watchdog_in = 1'b1;
    reset_cfg = 8'h00;
    step(3);
    reset_cfg = 8'h02;
    for (int i = 0; i < 4; i++) begin
      step(50);
      watchdog_in = ~watchdog_in;
      check("t3_no_fault", 32'(fault_latched), 0);
    end
    step(202);
    check("t3_fault_early", 32'(fault_latched), 0);
    step(1);
    check("t3_fault", 32'(fault_latched), 1);
    check("t3_state", st(), 3);
    check("t3_ch", ch(), 0);
    check("t3_ack", 32'(reset_ack), 1);
    check("t3_sts_fault", 32'(reset_sts[21]), 1);
    watchdog_in = ~watchdog_in;
    ch_mask = 4'b0101;
    step(1);
    check("t5_mask_ch", ch(), 4'b1010);
    check("t5_mask_sts", 32'(reset_sts[3:0]), 4'b1010);
    ch_mask = 4'hF;
    step(1);
    check("t5_unmask_ch", ch(), 0);
    step(40);
    check("t3_fault_holds", st(), 3);
    reset_cfg = 8'h00;
    step(1);
    check("t3_wd_off_holds", 32'(fault_latched), 1);
    reset_cfg = 8'h42;
    step(1);
    check("t3_clr_hold", st(), 0);
    check("t3_clr_fault", 32'(fault_latched), 0);
    check("t3_clr_ack", 32'(reset_ack), 0);
    step(1);
    check("t3_clr_seq", st(), 1);
    check("t3_clr_ch", ch(), 4'h1);
    reset_cfg = 8'h0C;
    step(35);
    check("t4_run", st(), 2);
    check("t4_run_ch", ch(), 4'hF);
    instant_reset_in = 1'b1;
    step(2);
    check("t4_inst_early", ch(), 4'hF);
    check("t4_ack_early", 32'(reset_ack), 0);
    step(1);
    check("t4_inst_ch", ch(), 0);
    check("t4_inst_ack", 32'(reset_ack), 1);
    check("t4_inst_hold", st(), 0);
    check("t4_sts_inst", 32'(reset_sts[20]), 1);
    step(2);
    instant_reset_in = 1'b0;
    step(2);
    check("t4_rel_early_ch", ch(), 0);
    check("t4_rel_early_ack", 32'(reset_ack), 1);
    step(1);
    check("t4_restart_ch", ch(), 4'h1);
    check("t4_restart_ack", 32'(reset_ack), 0);
    check("t4_restart_seq", st(), 1);
    step(5);
    #2 peripheral_areset = 1'b1;
    #1;
    check("t6_ch", ch(), 0);
    check("t6_sts", reset_sts, 0);
    check("t6_flags", 32'({fault_latched, reset_ack, alive_signal, master_trigger}), 0);
    @(negedge clk);
    peripheral_areset = 1'b0;
    step(1);
    check("t6_resume_ch", ch(), 4'h1);
    check("t6_resume_seq", st(), 1);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
